// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard sequencer.
package pipe_pkg;
   typedef enum logic {RUN, MD_WAIT} state_e;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int MD_LAT_DEF = 4;
endpackage

// File: rtl/sat_cnt32.sv
// sat_cnt32: 32-bit event counter with enable, sticks at all-ones.
module sat_cnt32 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   output logic [31:0] cnt_o
);
   logic [31:0] cnt_q;
   logic [31:0] cnt_d;
   always_comb cnt_d = (en_i && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / branch-flush / MUL-DIV stall sequencer for a 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to add saturating perf counters on lu, flush and MD stall cycles.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_LAT = MD_LAT_DEF,
   parameter int CNT_W  = $clog2(MD_LAT + 1)
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_uses_rt_i,
   input  logic       id_muldiv_i,
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rt_i,
   input  logic       ex_branch_taken_i,
   output logic       pc_write_o,
   output logic       ifid_write_o,
   output logic       ifid_flush_o,
   output logic       idex_bubble_o,
   output logic       idex_hold_o,
   output logic       exmem_bubble_o,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0] perf_lu_o,
   output logic [31:0] perf_flush_o,
   output logic [31:0] perf_md_o,
`endif
   output logic       busy_o
);
   localparam bit MD_EN = MD_LAT >= 2;
   localparam logic [CNT_W-1:0] LAT = CNT_W'(MD_LAT);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_e           st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lu, run, stall, last, br, lus, issue;

   assign lu = ex_mem_read_i && ex_rt_i != REG_ZERO &&
               (ex_rt_i == id_rs_i || (id_uses_rt_i && ex_rt_i == id_rt_i));
   assign run   = st_q == RUN;
   assign stall = !run && cnt_q > ONE;
   assign last  = !run && cnt_q == ONE;
   assign br    = run && ex_branch_taken_i;
   assign lus   = run && !ex_branch_taken_i && lu;
   // A MUL/DIV issues from a clean RUN cycle or chains from the final EX cycle of the previous one.
   assign issue = MD_EN && id_muldiv_i && ((run && !ex_branch_taken_i && !lu) || last);

   always_comb begin
      st_d  = RUN;
      cnt_d = '0;
      if (stall) begin
         st_d  = MD_WAIT;
         cnt_d = cnt_q - ONE;
      end else if (issue) begin
         st_d  = MD_WAIT;
         cnt_d = LAT;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         st_q  <= RUN;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end

   assign pc_write_o     = !rst_i && !stall && !lus;
   assign ifid_write_o   = !rst_i && !stall && !lus;
   assign ifid_flush_o   = !rst_i && br;
   assign idex_bubble_o  = !rst_i && (br || lus);
   assign idex_hold_o    = !rst_i && stall;
   assign exmem_bubble_o = !rst_i && stall;
   assign busy_o         = !rst_i && !run;

`ifdef HAZARD_PERF_CNT_EN
   sat_cnt32 u_perf_lu    (.clk_i(clk_i), .rst_i(rst_i), .en_i(lus),   .cnt_o(perf_lu_o));
   sat_cnt32 u_perf_flush (.clk_i(clk_i), .rst_i(rst_i), .en_i(br),    .cnt_o(perf_flush_o));
   sat_cnt32 u_perf_md    (.clk_i(clk_i), .rst_i(rst_i), .en_i(stall), .cnt_o(perf_md_o));
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus randomized checking of pipe_hazard_ctrl against a cycle-count model.
module tb_pipe_hazard_ctrl;
   localparam int LAT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, id_muldiv, ex_mem_read, ex_br;
   logic       pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble, busy;
   logic [6:0] got;
   int         checks = 0;
   int         errors = 0;
   int         rem = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MD_LAT(LAT)) dut (
      .clk_i(clk), .rst_i(rst),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt), .id_muldiv_i(id_muldiv),
      .ex_mem_read_i(ex_mem_read), .ex_rt_i(ex_rt), .ex_branch_taken_i(ex_br),
      .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
      .idex_bubble_o(idex_bubble), .idex_hold_o(idex_hold), .exmem_bubble_o(exmem_bubble),
      .busy_o(busy)
   );

   assign got = {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble, busy};

   // rem = EX cycles still owed to the MUL/DIV in flight, 0 when the pipe runs freely
   function automatic bit m_lu();
      return ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
   endfunction

   function automatic logic [6:0] model_out();
      if (rst) return 7'b0000000;
      if (rem > 1) return 7'b0000111;
      if (rem == 1) return 7'b1100001;
      if (ex_br) return 7'b1111000;
      if (m_lu()) return 7'b0001000;
      return 7'b1100000;
   endfunction

   function automatic int model_next();
      if (rst) return 0;
      if (rem > 1) return rem - 1;
      if (id_muldiv && LAT >= 2 && (rem == 1 || (!ex_br && !m_lu()))) return LAT;
      return 0;
   endfunction

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%b exp=%b (pc,ifw,flush,bub,hold,exb,busy) rem=%0d t=%0t",
                  name, act, exp, rem, $time);
      end
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic md, input logic mr, input logic [4:0] ert, input logic b);
      id_rs = rs; id_rt = rt; id_uses_rt = urt; id_muldiv = md;
      ex_mem_read = mr; ex_rt = ert; ex_br = b;
   endtask

   task automatic cycle(input string name, input logic [6:0] lit, input bit use_lit);
      #1;
      chk({name, "_model"}, got, model_out());
      if (use_lit) chk(name, got, lit);
      @(posedge clk);
      rem = model_next();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cycle("reset_state", 7'b0000000, 1);
      rst = 1'b0;
      drive(8, 0, 0, 0, 1, 8, 0);  cycle("lu_rs",        7'b0001000, 1);
      drive(0, 0, 0, 0, 0, 0, 0);  cycle("after_lu",     7'b1100000, 1);
      drive(0, 0, 0, 0, 1, 0, 0);  cycle("lu_r0",        7'b1100000, 1);
      drive(1, 8, 0, 0, 1, 8, 0);  cycle("rt_unused",    7'b1100000, 1);
      drive(1, 8, 1, 0, 1, 8, 0);  cycle("lu_rt",        7'b0001000, 1);
      drive(8, 0, 0, 1, 1, 8, 1);  cycle("br_over_all",  7'b1111000, 1);
      drive(0, 0, 0, 0, 0, 0, 0);  cycle("br_no_issue",  7'b1100000, 1);
      drive(0, 0, 0, 1, 0, 0, 0);  cycle("mul_issue",    7'b1100000, 1);
      drive(8, 0, 0, 0, 1, 8, 1);  cycle("md_cnt4_ign",  7'b0000111, 1);
      drive(0, 0, 0, 0, 0, 0, 0);  cycle("md_cnt3",      7'b0000111, 1);
      cycle("md_cnt2",      7'b0000111, 1);
      drive(0, 0, 0, 1, 0, 0, 0);  cycle("md_last_chain", 7'b1100001, 1);
      drive(0, 0, 0, 0, 0, 0, 0);  cycle("chain_cnt4",   7'b0000111, 1);
      cycle("chain_cnt3",   7'b0000111, 1);
      cycle("chain_cnt2",   7'b0000111, 1);
      cycle("chain_last",   7'b1100001, 1);
      cycle("back_run",     7'b1100000, 1);
      drive(0, 0, 0, 1, 0, 0, 0);  cycle("mul2_issue",   7'b1100000, 1);
      drive(0, 0, 0, 0, 0, 0, 0);  cycle("mul2_cnt4",    7'b0000111, 1);
      #1 chk("mul2_cnt3", got, 7'b0000111);
      #2 rst = 1'b1;
      #1 chk("async_rst", got, 7'b0000000);
      rem = 0;
      @(negedge clk);
      cycle("in_rst", 7'b0000000, 1);
      rst = 1'b0;
      cycle("post_rst", 7'b1100000, 1);
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
               $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
               5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
         cycle("rand", 7'b0, 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and stall sequencer for the 5-stage MIPS pipeline. It drives the write-enable, flush, bubble and hold controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It handles three cases: load-use stalls, taken-branch flushes, and multi-cycle MUL/DIV occupancy of EX. Output controls are combinational from registered state plus current-cycle inputs.

Parameters:
MD_LAT, 4, total EX-stage cycles a MUL/DIV occupies (legal values >= 1; 1 means single-cycle, and MD_WAIT is never entered)
CNT_W, $clog2(MD_LAT+1), width of the occupancy counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
id_rs_i  in  5  rs field of the instruction in ID
id_rt_i  in  5  rt field of the instruction in ID
id_uses_rt_i  in  1  ID instruction reads rt as a source
id_muldiv_i  in  1  ID instruction is a multi-cycle MUL/DIV
ex_mem_read_i  in  1  instruction in EX is a load
ex_rt_i  in  5  destination register of the load in EX
ex_branch_taken_i  in  1  branch resolved taken in EX this cycle
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID load enable
ifid_flush_o  out  1  IF/ID clear to NOP
idex_bubble_o  out  1  ID/EX loads zero controls (REG_WRITE=0, ALU_OP=0)
idex_hold_o  out  1  ID/EX keeps its current contents
exmem_bubble_o  out  1  EX/MEM loads zero controls
busy_o  out  1  FSM is in MD_WAIT

Behaviour:
- State: st ∈ {RUN, MD_WAIT}; cnt[CNT_W-1:0].
- Reset (async, rst_i=1): st=RUN, cnt=0. While rst_i=1, every output is forced to 0.
- lu (load-use) = ex_mem_read_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || (id_uses_rt_i && ex_rt_i==id_rt_i)). Register $0 never hazards.
- RUN, priority order:
  1. ex_branch_taken_i=1: ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1, ifid_write_o=1. Overrides lu and id_muldiv_i; no MUL/DIV issue.
  2. Else lu=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, for one cycle. No MUL/DIV issue that cycle, even if id_muldiv_i=1.
  3. Else: pc_write_o=1, ifid_write_o=1, all others 0. If id_muldiv_i=1 and MD_LAT>=2, the next state is MD_WAIT with cnt=MD_LAT.
- MD_WAIT, cnt>1: pc_write_o=0, ifid_write_o=0, idex_hold_o=1, exmem_bubble_o=1, busy_o=1. cnt decrements each cycle.
- MD_WAIT, cnt==1: last EX cycle. Outputs are the RUN case-3 values with busy_o=1; EX/MEM captures the result.
  - If id_muldiv_i=1, re-enter MD_WAIT with cnt=MD_LAT.
  - Otherwise go to RUN and set cnt=0.
- Net effect: a MUL/DIV spends exactly MD_LAT cycles in EX and inserts MD_LAT-1 stall cycles.
- ex_branch_taken_i and ex_mem_read_i are ignored in MD_WAIT, because EX holds the MUL/DIV.
- Reset mid-MD_WAIT: immediate return to RUN; the counter is discarded.
- Never assert idex_bubble_o and idex_hold_o together. Never assert ifid_flush_o with ifid_write_o=0.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds three outputs, each 32 bits wide and saturating at 0xFFFFFFFF:
  - perf_lu_o: increments on each lu stall cycle
  - perf_flush_o: increments on each taken-branch flush
  - perf_md_o: increments on each MD_WAIT cycle with cnt>1
  - All three clear on rst_i.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: state enum (RUN, MD_WAIT); REG_ZERO=5'd0; default MD_LAT.
- No sub-module, except sat_cnt32 (32-bit saturating counter with enable), instantiated three times only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load to r8 in EX (ex_mem_read_i=1, ex_rt_i=8) with id_rs_i=8 -> one cycle of pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; next cycle normal.
- Load to r0 matching id_rs_i=0, then load to r8 with id_rt_i=8 and id_uses_rt_i=0 -> no stall in either case.
- ex_branch_taken_i=1 together with lu=1 and id_muldiv_i=1 -> ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1; st stays RUN.
- MUL issued with MD_LAT=4 -> 3 cycles of stall with idex_hold_o=1, exmem_bubble_o=1 and cnt 4,3,2; then one advance cycle at cnt=1; busy_o=1 for 4 cycles; back to RUN.
- Back-to-back MUL in ID during the cnt==1 cycle -> re-enters MD_WAIT with cnt=4 and no RUN gap.
- rst_i pulsed asynchronously mid-MD_WAIT (cnt=3) -> outputs 0 immediately; after release st=RUN, pc_write_o=1; perf counters (if enabled) are 0.
